// File: rtl/voice_allocator_if.sv
// voice_allocator_if: event handshake between a note producer and the voice allocator
interface voice_allocator_if #(parameter int NOTE_W = 7, parameter int TICKS_W = 24);
  logic               ev_valid;
  logic               ev_ready;
  logic               ev_on;
  logic [NOTE_W-1:0]  ev_note;
  logic [TICKS_W-1:0] ev_ticks;
  logic               ev_done;
  logic               ev_stolen;
  modport master (output ev_valid, ev_on, ev_note, ev_ticks, input ev_ready, ev_done, ev_stolen);
  modport slave  (input ev_valid, ev_on, ev_note, ev_ticks, output ev_ready, ev_done, ev_stolen);
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: 3-slot age-ordered voice scheduler with oldest-voice stealing
module voice_allocator #(
  parameter int NOTE_W  = 7,
  parameter int TICKS_W = 24
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  voice_allocator_if.slave    ev,
  input  logic                panic_clear,
  output logic [3:0]          voice_count,
  output logic [TICKS_W-1:0]  ticks0,
  output logic [TICKS_W-1:0]  ticks1,
  output logic [TICKS_W-1:0]  ticks2,
  output logic [NOTE_W-1:0]   note0,
  output logic [NOTE_W-1:0]   note1,
  output logic [NOTE_W-1:0]   note2
);
  typedef enum logic [1:0] {IDLE, MATCH, COMMIT} state_t;
  state_t state, nxt_state;
  logic               lat_on;
  logic [NOTE_W-1:0]  lat_note;
  logic [TICKS_W-1:0] lat_ticks;
  logic [NOTE_W-1:0]  note_r [3];
  logic [NOTE_W-1:0]  note_n [3];
  logic [TICKS_W-1:0] ticks_r [3];
  logic [TICKS_W-1:0] ticks_n [3];
  logic [3:0]         count_n;
  logic [2:0]         hit;
  logic               hit_any;
  logic [1:0]         hit_idx;
  logic               steal_n;
  logic               done_r;
  logic               stolen_r;

  assign ev.ev_ready  = state == IDLE && !panic_clear;
  assign ev.ev_done   = done_r;
  assign ev.ev_stolen = stolen_r;
  assign {note0, note1, note2}    = {note_r[0], note_r[1], note_r[2]};
  assign {ticks0, ticks1, ticks2} = {ticks_r[0], ticks_r[1], ticks_r[2]};
  assign hit = {voice_count > 4'd2 && note_r[2] == lat_note,
                voice_count > 4'd1 && note_r[1] == lat_note,
                voice_count > 4'd0 && note_r[0] == lat_note};

  // state register; panic drops any in-flight event straight back to IDLE
  always_ff @(posedge CLOCK_50)
    state <= (reset || panic_clear) ? IDLE : nxt_state;

  // next state: accept in IDLE, then one cycle each for match and commit
  always_comb begin
    nxt_state = state;
    nxt_state = state == IDLE  ? ((ev.ev_valid && ev.ev_ready) ? MATCH : IDLE) :
                state == MATCH ? COMMIT : IDLE;
  end

  // slot contents after committing the latched event; inactive slots stay zero
  always_comb begin
    note_n  = note_r;
    ticks_n = ticks_r;
    count_n = voice_count;
    steal_n = 1'b0;
    if (lat_on) begin
      if (lat_ticks != '0) begin
        if (hit_any)
          ticks_n[hit_idx] = lat_ticks;
        else if (voice_count < 4'd3) begin
          note_n[voice_count[1:0]]  = lat_note;
          ticks_n[voice_count[1:0]] = lat_ticks;
          count_n = voice_count + 4'd1;
        end else begin
          note_n  = '{note_r[1], note_r[2], lat_note};
          ticks_n = '{ticks_r[1], ticks_r[2], lat_ticks};
          steal_n = 1'b1;
        end
      end
    end else if (hit_any) begin
      note_n[0]  = hit_idx == 2'd0 ? note_r[1] : note_r[0];
      note_n[1]  = hit_idx <= 2'd1 ? note_r[2] : note_r[1];
      note_n[2]  = '0;
      ticks_n[0] = hit_idx == 2'd0 ? ticks_r[1] : ticks_r[0];
      ticks_n[1] = hit_idx <= 2'd1 ? ticks_r[2] : ticks_r[1];
      ticks_n[2] = '0;
      count_n = voice_count - 4'd1;
    end
  end

  // datapath: latch on accept, register the match, publish every slot on one edge
  always_ff @(posedge CLOCK_50) begin
    if (reset || panic_clear) begin
      lat_on      <= 1'b0;
      lat_note    <= '0;
      lat_ticks   <= '0;
      hit_any     <= 1'b0;
      hit_idx     <= '0;
      done_r      <= 1'b0;
      stolen_r    <= 1'b0;
      voice_count <= '0;
      note_r      <= '{default: '0};
      ticks_r     <= '{default: '0};
    end else begin
      done_r   <= state == COMMIT;
      stolen_r <= state == COMMIT && steal_n;
      if (ev.ev_valid && ev.ev_ready) begin
        lat_on    <= ev.ev_on;
        lat_note  <= ev.ev_note;
        lat_ticks <= ev.ev_ticks;
      end
      if (state == MATCH) begin
        hit_any <= |hit;
        hit_idx <= hit[0] ? 2'd0 : hit[1] ? 2'd1 : 2'd2;
      end
      if (state == COMMIT) begin
        note_r      <= note_n;
        ticks_r     <= ticks_n;
        voice_count <= count_n;
      end
    end
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler that sits in front of the 3-voice waveform generator.
- Accepts note-on/note-off events over a valid/ready handshake and keeps the three voice slots packed: active voices always occupy slots 0..voice_count-1.
- Drives voice_count and ticks0..ticks2 directly into the generator. When all slots are full, a new note steals the oldest voice.

Parameters:
- NOTE_W, 7, width of the note identifier (MIDI-style key number).
- TICKS_W, 24, width of the ticks-per-sample pitch value.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event this cycle.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_W  key identifier.
- ev_ticks  in  TICKS_W  pitch for note-on; ignored for note-off.
- panic_clear  in  1  synchronous all-notes-off.
- voice_count  out  4  number of active voices, 0..3.
- ticks0, ticks1, ticks2  out  TICKS_W each  pitch per slot; 0 when the slot is inactive.
- note0, note1, note2  out  NOTE_W each  key held in each slot; 0 when inactive.
- ev_done  out  1  one-cycle pulse when an accepted event is committed.
- ev_stolen  out  1  one-cycle pulse coincident with ev_done when the oldest voice was evicted.

Behaviour:
- Reset (synchronous): all outputs 0, except ev_ready, which goes to 1 once the FSM is in IDLE. FSM goes to IDLE. Latched event is cleared.
- Clock and reset are fixed: a single clock, CLOCK_50, and a synchronous, active-high reset, reset.
- FSM has three states: IDLE, MATCH, COMMIT.
  - IDLE: ev_ready = 1 & !panic_clear. On ev_valid & ev_ready, latch ev_on/ev_note/ev_ticks and go to MATCH.
  - MATCH: compute hit[i] = (i < voice_count) & (note_i == latched note). Register hit and its lowest index. Go to COMMIT.
  - COMMIT: apply the update below. Pulse ev_done (plus ev_stolen if applicable). Go to IDLE.
- Timing: acceptance at edge T0. New slot/count values and the ev_done pulse are visible after edge T2. ev_ready is low for the cycles following T0 and T1 and high again after T2. Maximum throughput is one event per 3 cycles.
- Outputs change only in COMMIT, so all slot fields and voice_count update on the same edge and the generator never sees a partial update.
- Note-on rules:
  - ev_ticks = 0: event consumed, no slot change, ev_done still pulses.
  - Note already held (hit): overwrite that slot's ticks in place; voice_count unchanged.
  - No hit and voice_count < 3: write note/ticks into slot[voice_count]; voice_count + 1.
  - No hit and voice_count = 3: shift slot1 to slot0 and slot2 to slot1, write the new note to slot2, count stays 3, ev_stolen = 1.
- Note-off rules:
  - Hit at slot k: shift every slot j > k down to j-1, zero the vacated top slot, voice_count - 1.
  - No hit, or voice_count = 0: event consumed, no change.
- Slot order always equals age order: slot0 is the oldest.
- panic_clear, in any state: next edge zeroes all slots, sets voice_count = 0, drops any latched event without an ev_done pulse, and returns to IDLE. ev_ready is 0 during any cycle with panic_clear high.
- Simultaneous reset and panic_clear: reset wins; the end result is identical.
- A change on ev_* while ev_ready = 0 has no effect. The producer must hold the event until ev_valid & ev_ready.
- voice_count never exceeds 3 and never underflows.

Test Plan:
- Reset, then note-on A (note 60, ticks 1000) -> after 3 edges: voice_count = 1, ticks0 = 1000, note0 = 60, ev_done pulses once, ev_ready back to 1.
- Note-on 60/1000, 64/800, 67/670 -> count = 3, slots = (60,64,67). Then note-off 64 -> count = 2, slots = (60,67), ticks2 = 0, note2 = 0.
- Three voices held (60,64,67), then note-on 72/500 -> slots = (64,67,72), count = 3, ev_stolen and ev_done pulse together.
- Note-on 60/1000, then note-on 60/900 -> count remains 1, ticks0 = 900. Note-off 50 (absent) -> no change, ev_done pulses.
- ev_valid held high with back-to-back events -> ev_ready low for 2 cycles after each acceptance, each event committed exactly once, in order.
- With 2 voices active, assert panic_clear during MATCH -> next edge count = 0, all ticks/notes 0, no ev_done pulse, FSM in IDLE. A synchronous reset applied mid-event gives the same result.
